// File: rtl/int_controller.sv
// Three-source nesting interrupt controller with a three-deep EPC/priority
// stack. A RUN/ENTER/LEAVE state machine produces a one-cycle take or return
// pulse. The instruction decoder supplies eret/cli/sti.
//
// Handshake: there is no valid/ready pair on this block. int_take and int_ret
// are single-cycle strobes that the fetch unit must act on in the cycle they
// are high. Both are decoded directly from the state register, so an
// asynchronous reset drops them at once.
module int_controller #(
  parameter logic [31:0] VEC_BASE = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  irq,
  input  logic [4:0]  Int_ctrl,
  input  logic [31:0] pc_ret,
  input  logic        halt,
  output logic        int_take,
  output logic [31:0] int_vector,
  output logic        int_ret,
  output logic [31:0] epc_out,
  output logic        ie,
  output logic [2:0]  pending,
  output logic [1:0]  level,
  output logic [1:0]  cur_pri,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ENTER = 2'd1,
    LEAVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  irq_q;
  logic [2:0]  pending_q;
  logic        ie_q;
  logic [1:0]  level_q;
  logic [1:0]  cur_pri_q;
  logic [31:0] int_vector_q;
  logic [31:0] epc_q [3];
  logic [1:0]  pri_q [3];

  logic        eret, cli, sti;
  logic        ctrl_unused;
  logic [1:0]  src;
  logic [1:0]  src_pri;
  logic        take;
  logic        leave_go;
  logic [2:0]  clr_mask;

  assign eret = Int_ctrl[4];
  assign cli  = Int_ctrl[3];
  assign sti  = Int_ctrl[2];
  // mtc/mfc belong to the coprocessor register path, not to this block.
  assign ctrl_unused = &{1'b0, Int_ctrl[1:0]};

  // Pick the highest-priority pending source and decide entry / return.
  always_comb begin
    src      = 2'd0;
    if (pending_q[2])      src = 2'd2;
    else if (pending_q[1]) src = 2'd1;
    src_pri  = src + 2'd1;
    take     = (state_q == RUN) && ie_q && !halt && !eret &&
               (level_q != 2'd3) && (|pending_q) && (src_pri > cur_pri_q);
    leave_go = (state_q == RUN) && eret && (level_q != 2'd0);
    clr_mask = take ? (3'b001 << src) : 3'b000;
  end

  // Next-state logic; ENTER and LEAVE always last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (leave_go)  state_d = LEAVE;
        else if (take) state_d = ENTER;
      end
      ENTER:   state_d = RUN;
      LEAVE:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Edge detection and pending latch; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= 3'b000;
      pending_q <= 3'b000;
    end else begin
      irq_q     <= irq;
      pending_q <= (pending_q & ~clr_mask) | (irq & ~irq_q);
    end
  end

  // Global enable: entry clears it, cli beats sti, return re-enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (take)     ie_q <= 1'b0;
          else if (cli) ie_q <= 1'b0;
          else if (sti) ie_q <= 1'b1;
        end
        LEAVE:   ie_q <= 1'b1;
        default: ie_q <= ie_q;
      endcase
    end
  end

  // Stack push on entry, pop at the end of LEAVE, vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q      <= 2'd0;
      cur_pri_q    <= 2'd0;
      int_vector_q <= 32'h0;
      for (int i = 0; i < 3; i++) begin
        epc_q[i] <= 32'h0;
        pri_q[i] <= 2'd0;
      end
    end else if (take) begin
      epc_q[level_q] <= pc_ret;
      pri_q[level_q] <= src_pri;
      level_q        <= level_q + 2'd1;
      cur_pri_q      <= src_pri;
      int_vector_q   <= VEC_BASE + {26'd0, src, 4'd0};
    end else if (state_q == LEAVE) begin
      level_q   <= level_q - 2'd1;
      cur_pri_q <= (level_q == 2'd1) ? 2'd0 : pri_q[level_q - 2'd2];
    end
  end

  assign int_take   = (state_q == ENTER);
  assign int_ret    = (state_q == LEAVE);
  assign int_vector = int_vector_q;
  assign epc_out    = (level_q != 2'd0) ? epc_q[level_q - 2'd1] : 32'h0;
  assign ie         = ie_q;
  assign pending    = pending_q;
  assign level      = level_q;
  assign cur_pri    = cur_pri_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: entry, nesting, priority, simultaneous
// control events, depth limit, halt and asynchronous reset.
module tb_int_controller;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_ERET = 5'b10000;
  localparam logic [4:0] C_CLI  = 5'b01000;
  localparam logic [4:0] C_STI  = 5'b00100;
  localparam logic [4:0] C_MTC  = 5'b00010;
  localparam logic [4:0] C_MFC  = 5'b00001;

  logic        clk;
  logic        rst_n;
  logic [2:0]  irq;
  logic [4:0]  Int_ctrl;
  logic [31:0] pc_ret;
  logic        halt;
  logic        int_take;
  logic [31:0] int_vector;
  logic        int_ret;
  logic [31:0] epc_out;
  logic        ie;
  logic [2:0]  pending;
  logic [1:0]  level;
  logic [1:0]  cur_pri;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  int_controller #(.VEC_BASE(32'h0000_4000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .Int_ctrl   (Int_ctrl),
    .pc_ret     (pc_ret),
    .halt       (halt),
    .int_take   (int_take),
    .int_vector (int_vector),
    .int_ret    (int_ret),
    .epc_out    (epc_out),
    .ie         (ie),
    .pending    (pending),
    .level      (level),
    .cur_pri    (cur_pri),
    .dbg_state  (dbg_state)
  );

  // Clock and reset generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl_pulse(input logic [4:0] c);
    Int_ctrl = c;
    tick();
    Int_ctrl = C_NONE;
  endtask

  initial begin
    rst_n = 1'b0; irq = 3'b000; Int_ctrl = C_NONE; pc_ret = 32'h0; halt = 1'b0;
    tick(); tick();
    check("rst_ie", ie, 0);
    check("rst_pending", pending, 0);
    check("rst_level", level, 0);
    check("rst_cur_pri", cur_pri, 0);
    check("rst_take", int_take, 0);
    check("rst_ret", int_ret, 0);
    check("rst_vector", int_vector, 0);
    check("rst_epc", epc_out, 0);
    rst_n = 1'b1;

    ctrl_pulse(C_MTC | C_MFC);
    check("mtc_mfc_ie", ie, 0);
    check("mtc_mfc_state", dbg_state, 0);

    // Basic entry.
    ctrl_pulse(C_STI);
    check("sti_ie", ie, 1);
    irq = 3'b001; pc_ret = 32'h40; tick();
    check("basic_pending", pending, 3'b001);
    check("basic_no_take_yet", int_take, 0);
    irq = 3'b000; tick();
    check("basic_take", int_take, 1);
    check("basic_vector", int_vector, 32'h4000);
    check("basic_epc", epc_out, 32'h40);
    check("basic_level", level, 1);
    check("basic_cur_pri", cur_pri, 1);
    check("basic_ie", ie, 0);
    check("basic_pending_clr", pending, 0);
    tick();
    check("basic_take_1cyc", int_take, 0);

    // Nesting.
    ctrl_pulse(C_STI);
    check("nest_ie", ie, 1);
    irq = 3'b100; pc_ret = 32'h4008; tick();
    irq = 3'b000; tick();
    check("nest_take", int_take, 1);
    check("nest_vector", int_vector, 32'h4020);
    check("nest_level", level, 2);
    check("nest_cur_pri", cur_pri, 3);
    check("nest_epc", epc_out, 32'h4008);
    tick();
    ctrl_pulse(C_ERET);
    check("nest_ret", int_ret, 1);
    check("nest_ret_epc", epc_out, 32'h4008);
    check("nest_ret_level", level, 2);
    tick();
    check("nest_ret_1cyc", int_ret, 0);
    check("nest_pop_level", level, 1);
    check("nest_pop_cur_pri", cur_pri, 1);
    check("nest_pop_ie", ie, 1);
    check("nest_pop_epc", epc_out, 32'h40);
    ctrl_pulse(C_ERET);
    check("ret0_ret", int_ret, 1);
    check("ret0_epc", epc_out, 32'h40);
    tick();
    check("ret0_level", level, 0);
    check("ret0_cur_pri", cur_pri, 0);
    check("ret0_epc_zero", epc_out, 0);
    check("ret0_ie", ie, 1);

    // Priority and blocking.
    irq = 3'b110; tick();
    check("prio_pending", pending, 3'b110);
    tick();
    check("prio_take", int_take, 1);
    check("prio_vector", int_vector, 32'h4020);
    check("prio_pending_left", pending, 3'b010);
    check("prio_cur_pri", cur_pri, 3);
    tick();
    irq = 3'b010; ctrl_pulse(C_STI);
    check("block_ie", ie, 1);
    irq = 3'b110; tick();
    check("block_pending", pending, 3'b110);
    tick(); tick();
    check("block_no_take", int_take, 0);
    check("block_level", level, 1);
    check("block_pending_held", pending, 3'b110);
    ctrl_pulse(C_ERET);
    check("block_ret", int_ret, 1);
    tick();
    check("block_run_gap", int_take, 0);
    check("block_level0", level, 0);
    tick();
    check("block_take_after", int_take, 1);
    check("block_cur_pri", cur_pri, 3);
    check("block_pending_after", pending, 3'b010);
    tick();
    ctrl_pulse(C_ERET);
    tick(); tick();
    check("irq1_take", int_take, 1);
    check("irq1_cur_pri", cur_pri, 2);
    check("irq1_vector", int_vector, 32'h4010);
    check("irq1_pending", pending, 0);
    tick();

    // eret beats a same-cycle eligible interrupt.
    irq = 3'b000; ctrl_pulse(C_STI);
    irq = 3'b100; tick();
    check("sim_pending", pending, 3'b100);
    ctrl_pulse(C_ERET);
    check("sim_leave_first", int_ret, 1);
    check("sim_no_take", int_take, 0);
    check("sim_pending_kept", pending, 3'b100);
    tick();
    check("sim_gap_take", int_take, 0);
    check("sim_gap_level", level, 0);
    tick();
    check("sim_enter_late", int_take, 1);
    check("sim_enter_level", level, 1);
    check("sim_enter_cur_pri", cur_pri, 3);
    tick();

    // cli and sti together.
    ctrl_pulse(C_STI);
    check("clisti_pre_ie", ie, 1);
    ctrl_pulse(C_CLI | C_STI);
    check("clisti_ie", ie, 0);

    // eret at level 0 is ignored.
    ctrl_pulse(C_ERET);
    tick();
    check("eret0_pre_level", level, 0);
    ctrl_pulse(C_ERET);
    check("eret0_no_ret", int_ret, 0);
    check("eret0_level", level, 0);
    tick();
    check("eret0_no_ret_later", int_ret, 0);

    // Depth limit.
    irq = 3'b000; tick();
    irq = 3'b001; pc_ret = 32'h100; tick();
    irq = 3'b000; tick();
    check("depth1_take", int_take, 1);
    check("depth1_level", level, 1);
    tick();
    ctrl_pulse(C_STI);
    irq = 3'b010; pc_ret = 32'h200; tick();
    irq = 3'b000; tick();
    check("depth2_take", int_take, 1);
    check("depth2_level", level, 2);
    check("depth2_vector", int_vector, 32'h4010);
    tick();
    ctrl_pulse(C_STI);
    irq = 3'b100; pc_ret = 32'h300; tick();
    irq = 3'b000; tick();
    check("depth3_take", int_take, 1);
    check("depth3_level", level, 3);
    check("depth3_epc", epc_out, 32'h300);
    tick();
    ctrl_pulse(C_STI);
    check("depth3_ie", ie, 1);
    irq = 3'b001; pc_ret = 32'h999; tick();
    irq = 3'b000; tick();
    check("full_no_take", int_take, 0);
    check("full_pending", pending, 3'b001);
    tick();
    check("full_no_take2", int_take, 0);
    check("full_level", level, 3);
    check("full_epc", epc_out, 32'h300);

    // Halt blocks entries but not returns.
    halt = 1'b1;
    ctrl_pulse(C_ERET);
    check("halt_ret", int_ret, 1);
    check("halt_ret_epc", epc_out, 32'h300);
    tick();
    check("pop3_level", level, 2);
    check("pop3_cur_pri", cur_pri, 2);
    check("pop3_epc", epc_out, 32'h200);
    ctrl_pulse(C_ERET);
    tick();
    check("pop2_level", level, 1);
    check("pop2_cur_pri", cur_pri, 1);
    check("pop2_epc", epc_out, 32'h100);
    ctrl_pulse(C_ERET);
    tick();
    check("pop1_level", level, 0);
    check("pop1_ie", ie, 1);
    pc_ret = 32'h500;
    tick(); tick();
    check("halt_no_take", int_take, 0);
    check("halt_pending", pending, 3'b001);
    halt = 1'b0; tick();
    check("unhalt_take", int_take, 1);
    check("unhalt_vector", int_vector, 32'h4000);
    check("unhalt_epc", epc_out, 32'h500);
    tick();

    // Reset in the middle of ENTER.
    ctrl_pulse(C_STI);
    irq = 3'b100; tick();
    irq = 3'b000; tick();
    check("rstenter_take", int_take, 1);
    check("rstenter_level", level, 2);
    #2 rst_n = 1'b0; irq = 3'b010;
    #1;
    check("async_take", int_take, 0);
    check("async_level", level, 0);
    check("async_pending", pending, 0);
    check("async_ie", ie, 0);
    check("async_cur_pri", cur_pri, 0);
    check("async_epc", epc_out, 0);
    check("async_vector", int_vector, 0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_edge", pending, 3'b010);
    check("post_rst_no_take", int_take, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 The block SHALL provide parameter VEC_BASE, default 32'h0000_4000, giving the base address of the interrupt handler vectors.
REQ-002 The block SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL provide port irq, input, 3 bits: external requests, level-held, rising-edge sensitive; irq[2] has highest priority.
REQ-005 The block SHALL provide port Int_ctrl, input, 5 bits, ordered {eret, cli, sti, mtc, mfc}, from the instruction decoder.
REQ-006 The block SHALL provide port pc_ret, input, 32 bits: address of the next instruction to resume at if interrupted.
REQ-007 The block SHALL provide port halt, input, 1 bit: CPU halted; blocks new entries.
REQ-008 The block SHALL provide port int_take, output, 1 bit: one-cycle pulse; redirect PC to int_vector.
REQ-009 The block SHALL provide port int_vector, output, 32 bits: handler address.
REQ-010 The block SHALL provide port int_ret, output, 1 bit: one-cycle pulse; redirect PC to epc_out.
REQ-011 The block SHALL provide port epc_out, output, 32 bits: top of the EPC stack.
REQ-012 The block SHALL provide the following status outputs:
- ie, 1 bit: global enable.
- pending, 3 bits: latched requests.
- level, 2 bits: nesting depth, 0-3.
- cur_pri, 2 bits: in-service priority; 0 = none, source i maps to i+1.

Function
REQ-013 Edge detection: the block SHALL register irq once.
- A 0->1 transition on irq[i] SHALL set pending[i] at the next edge.
- If set and clear of pending[i] occur in the same cycle, set SHALL win.
REQ-014 The FSM SHALL have the states RUN, ENTER and LEAVE.
- ENTER and LEAVE SHALL each last exactly one cycle and then return to RUN.
REQ-015 Entry decision in RUN SHALL require all of the following:
- ie=1, halt=0, eret=0, level<3;
- the highest-priority pending source s satisfies s+1 > cur_pri.
REQ-016 On the entry decision edge the block SHALL:
- write epc[level]<=pc_ret and pri[level]<=s+1;
- increment level; set cur_pri<=s+1; clear pending[s] and ie;
- set int_vector<=VEC_BASE+(s<<4), computed modulo 2^32;
- move state<=ENTER.
REQ-017 int_take SHALL be 1 only in ENTER, giving a latency of exactly 1 cycle from the decision edge; int_vector SHALL hold until the next entry.
REQ-018 Return: eret in RUN with level>0 SHALL move state<=LEAVE; eret with level=0 SHALL be ignored with no pulse.
REQ-019 In LEAVE the block SHALL drive int_ret=1 with epc_out=epc[level-1].
- At the end of LEAVE: decrement level; set cur_pri<=pri[level-2], or 0 if the new level is 0; set ie<=1.
REQ-020 epc_out SHALL equal epc[level-1] when level>0, and 32'h0 otherwise.
REQ-021 When eret and an eligible interrupt occur in the same RUN cycle, eret SHALL win; the interrupt SHALL be re-evaluated after LEAVE.
REQ-022 cli in RUN SHALL clear ie at the next edge and sti SHALL set it; when cli and sti are simultaneous, cli SHALL win.
REQ-023 Int_ctrl SHALL be ignored during ENTER and LEAVE.
REQ-024 mtc and mfc SHALL have no effect on this block.
REQ-025 halt=1 SHALL block entries only; edge latching, cli, sti and eret SHALL continue to operate.
REQ-026 At level=3, further requests SHALL remain pending and SHALL NOT overwrite the stack.
REQ-027 Equal or lower priority than cur_pri SHALL NOT preempt; it SHALL wait pending until cur_pri drops.

Reset
REQ-028 When rst_n=0 the block SHALL asynchronously force the following, independent of clk:
- state=RUN; ie=0; pending=0; level=0; cur_pri=0;
- int_take=0; int_ret=0; int_vector=0; epc_out=0;
- all stack entries=0; irq edge register=0.
REQ-029 Reset asserted during ENTER or LEAVE SHALL abort the pulse immediately; no push or pop SHALL complete.
REQ-030 After rst_n rises, an irq already high SHALL count as a rising edge on the first clk edge.

Verification
REQ-031 Basic entry: sti, then an irq[0] pulse with pc_ret=32'h0000_0040 -> int_take for 1 cycle, int_vector=32'h0000_4000, epc_out=32'h40, level=1, cur_pri=1, ie=0.
REQ-032 Nesting: inside the irq[0] handler, sti then irq[2] with pc_ret=32'h4008 -> int_vector=32'h4020, level=2, cur_pri=3; eret -> int_ret with epc_out=32'h4008, then level=1, cur_pri=1, ie=1.
REQ-033 Priority and blocking: irq[1] and irq[2] rise in the same cycle with ie=1 -> irq[2] is taken first and pending=3'b010; an equal-priority irq[2] during service stays pending until eret.
REQ-034 Simultaneous events: eret and an eligible irq in the same cycle -> LEAVE first, ENTER 2 cycles later; cli and sti together -> ie=0; eret at level=0 -> no int_ret.
REQ-035 Depth limit and halt: reach level=3, then a new irq -> stays pending with no int_take; halt=1 with pending set -> no entry until halt=0.
REQ-036 Reset: assert rst_n=0 during ENTER -> int_take drops immediately, level=0, pending=0, ie=0.
